// File: rtl/onchip_ram_burst_if.sv
// Avalon-MM style slave bus for the on-chip burst RAM.
// A command transfers when chipselect & (read | write) & clken & !waitrequest; read data returns on readdatavalid.
interface onchip_ram_burst_if #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 4
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                clken;
  logic                read;
  logic                write;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                error;

  modport slave (
    input  address, chipselect, clken, read, write, burstcount, writedata, byteenable,
    output waitrequest, readdata, readdatavalid, error
  );

  modport master (
    output address, chipselect, clken, read, write, burstcount, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid, error
  );
endinterface

// File: rtl/onchip_ram_burst.sv
// Parametrised single-port on-chip RAM slave with pipelined burst reads,
// byte-enabled writes, configurable read latency and a sticky protocol-error flag.
module onchip_ram_burst #(
  parameter int DATA_W       = 128,
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int BURST_W      = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  onchip_ram_burst_if.slave s1,
  output logic [0:0]        dbg_state
);
  localparam int NBYTES = DATA_W / 8;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RBURST = 1'b1;

  logic [0:0]         state;
  logic [ADDR_W-1:0]  burst_addr;
  logic [BURST_W-1:0] burst_left;
  logic [DATA_W-1:0]  mem [0:(2**ADDR_W)-1];

  logic               accept;
  logic               wr_acc;
  logic               rd_acc;
  logic               issue;
  logic [ADDR_W-1:0]  issue_addr;
  logic [BURST_W-1:0] eff_count;
  logic [DATA_W-1:0]  rd_q1;
  logic               v1;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               err_q;

  assign s1.waitrequest = (state == RBURST) || !s1.clken;
  assign accept     = s1.chipselect && (s1.read || s1.write) && s1.clken && !s1.waitrequest;
  // A simultaneous read+write is handled as a write; the read half is dropped.
  assign wr_acc     = accept && s1.write;
  assign rd_acc     = accept && s1.read && !s1.write;
  assign issue      = rd_acc || ((state == RBURST) && s1.clken);
  assign issue_addr = (state == RBURST) ? burst_addr : s1.address;
  assign eff_count  = (s1.burstcount == '0) ? BURST_W'(1) : s1.burstcount;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      burst_addr <= '0;
      burst_left <= '0;
    end else if (s1.clken) begin
      case (state)
        IDLE: begin
          if (rd_acc && (eff_count != BURST_W'(1))) begin
            burst_addr <= s1.address + ADDR_W'(1);
            burst_left <= eff_count - BURST_W'(1);
            state      <= RBURST;
          end
        end
        RBURST: begin
          burst_addr <= burst_addr + ADDR_W'(1);
          burst_left <= burst_left - BURST_W'(1);
          if (burst_left == BURST_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk_clk) begin
    if (wr_acc) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (s1.byteenable[i]) mem[s1.address][8*i +: 8] <= s1.writedata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rd_q1 <= '0;
      v1    <= 1'b0;
    end else if (s1.clken) begin
      v1 <= issue;
      if (issue) rd_q1 <= mem[issue_addr];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] rd_q2;
      logic              v2;
      always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
          rd_q2 <= '0;
          v2    <= 1'b0;
        end else if (s1.clken) begin
          v2 <= v1;
          if (v1) rd_q2 <= rd_q1;
        end
      end
      assign out_data  = rd_q2;
      assign out_valid = v2;
    end else begin : g_lat1
      assign out_data  = rd_q1;
      assign out_valid = v1;
    end
  endgenerate

  // Data registers only load on a real beat, so readdata holds between beats;
  // a stalled beat is withheld here and presented once clken returns.
  assign s1.readdata      = out_data;
  assign s1.readdatavalid = out_valid && s1.clken;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) err_q <= 1'b0;
    else if (wr_acc && (s1.read || (s1.byteenable == '0))) err_q <= 1'b1;
  end

  assign s1.error  = err_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_onchip_ram_burst.sv
// Directed bench for onchip_ram_burst: single reads/writes, bursts with wrap and
// stall, read+write collision, zero byteenable and reset mid-burst.
module tb_onchip_ram_burst;
  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 8;
  localparam int BURST_W = 4;
  localparam int LAT     = 1;

  localparam logic [DATA_W-1:0] W1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DATA_W-1:0] W2 = 128'h0123456789ABCDEF0123456789ABCDFF;
  localparam logic [DATA_W-1:0] D9 = 128'hCAFEF00D_DEADBEEF_12345678_9ABCDEF0;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] dbg_state;
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  onchip_ram_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

  onchip_ram_burst #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LATENCY(LAT), .BURST_W(BURST_W)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .s1(bus),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.clken      = 1'b1;
    bus.address    = '0;
    bus.burstcount = '0;
    bus.writedata  = '0;
    bus.byteenable = '0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [DATA_W/8-1:0] be);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.read       = 1'b0;
    bus.address    = addr;
    bus.writedata  = data;
    bus.byteenable = be;
    next_cycle();
    idle();
  endtask

  task automatic read_single(input string tag, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] exp);
    int lat = 0;
    logic [DATA_W-1:0] got = '0;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    bus.burstcount = BURST_W'(1);
    next_cycle();
    idle();
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (lat == 0 && bus.readdatavalid) begin
        lat = n;
        got = bus.readdata;
      end
      next_cycle();
      if (lat != 0) break;
    end
    chk({tag, " latency"}, DATA_W'(lat), DATA_W'(LAT));
    chk({tag, " data"}, got, exp);
  endtask

  task automatic run_burst(input string tag, input logic [ADDR_W-1:0] addr,
                           input logic [BURST_W-1:0] bc, input int stall_at, input int stall_len);
    int beats = (bc == '0) ? 1 : int'(bc);
    int nwait = 0;
    int nvalid = 0;
    int first = -1;
    int last = -1;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    bus.burstcount = bc;
    @(negedge clk);
    chk({tag, " accept waitrequest"}, DATA_W'(bus.waitrequest), '0);
    next_cycle();
    idle();
    for (int c = 1; c <= 14; c++) begin
      bus.clken = !(c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      if (!bus.clken) chk({tag, " stall valid"}, DATA_W'(bus.readdatavalid), '0);
      else if (bus.waitrequest) nwait++;
      if (bus.readdatavalid) begin
        nvalid++;
        if (first < 0) first = c;
        last = c;
        if (exp_q.size() > 0) chk({tag, " beat data"}, bus.readdata, exp_q.pop_front());
      end
      next_cycle();
    end
    bus.clken = 1'b1;
    chk({tag, " waitrequest cycles"}, DATA_W'(nwait), DATA_W'(beats - 1));
    chk({tag, " beat count"}, DATA_W'(nvalid), DATA_W'(beats));
    chk({tag, " first beat cycle"}, DATA_W'(first), DATA_W'(LAT));
    chk({tag, " last beat cycle"}, DATA_W'(last), DATA_W'(LAT + beats - 1 + stall_len));
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) next_cycle();
    @(negedge clk);
    chk("reset waitrequest", DATA_W'(bus.waitrequest), '0);
    chk("reset readdatavalid", DATA_W'(bus.readdatavalid), '0);
    chk("reset readdata", bus.readdata, '0);
    chk("reset error", DATA_W'(bus.error), '0);
    rst = 1'b0;
    next_cycle();

    // Full-word write and readback
    do_write(ADDR_W'(5), W1, '1);
    read_single("full word", ADDR_W'(5), W1);

    // Single byte lane write
    do_write(ADDR_W'(5), DATA_W'(8'hFF), 16'h0001);
    read_single("byte lane", ADDR_W'(5), W2);
    chk("no error after legal writes", DATA_W'(bus.error), '0);

    // Preload word i at address i
    foreach (exp_q[i]) exp_q.delete();
    do_write(ADDR_W'(254), DATA_W'(254), '1);
    do_write(ADDR_W'(255), DATA_W'(255), '1);
    for (int i = 0; i < 4; i++) do_write(ADDR_W'(i), DATA_W'(i), '1);

    // Burst across the address wrap
    exp_q.push_back(DATA_W'(254));
    exp_q.push_back(DATA_W'(255));
    exp_q.push_back(DATA_W'(0));
    exp_q.push_back(DATA_W'(1));
    run_burst("wrap burst", ADDR_W'(254), BURST_W'(4), 0, 0);

    // Burst with a 2-cycle clken stall in the middle
    for (int i = 0; i < 4; i++) exp_q.push_back(DATA_W'(i));
    run_burst("stall burst", ADDR_W'(0), BURST_W'(4), 2, 2);

    // burstcount of zero behaves as one beat
    exp_q.push_back(DATA_W'(254));
    run_burst("zero count", ADDR_W'(254), BURST_W'(0), 0, 0);

    // Read and write together: write wins, error latches
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.address    = ADDR_W'(9);
    bus.writedata  = D9;
    bus.byteenable = '1;
    next_cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("collision no valid", DATA_W'(bus.readdatavalid), '0);
      next_cycle();
    end
    chk("collision error", DATA_W'(bus.error), DATA_W'(1));
    read_single("collision write", ADDR_W'(9), D9);
    chk("error sticky", DATA_W'(bus.error), DATA_W'(1));

    // Reset during the second beat of an 8-beat burst
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = ADDR_W'(100);
    bus.burstcount = BURST_W'(8);
    next_cycle();
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset waitrequest", DATA_W'(bus.waitrequest), '0);
    chk("post-reset readdatavalid", DATA_W'(bus.readdatavalid), '0);
    chk("post-reset readdata", bus.readdata, '0);
    chk("post-reset error", DATA_W'(bus.error), '0);
    chk("post-reset state", DATA_W'(dbg_state), '0);
    read_single("read after reset", ADDR_W'(5), W2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("aborted burst silent", DATA_W'(bus.readdatavalid), '0);
      next_cycle();
    end

    // Write with no byte lanes enabled: memory untouched, error latches
    do_write(ADDR_W'(5), '1, '0);
    @(negedge clk);
    chk("zero byteenable error", DATA_W'(bus.error), DATA_W'(1));
    next_cycle();
    read_single("zero byteenable data", ADDR_W'(5), W2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
